main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk and rst.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  async active-low reset; 0 = reset asserted.
REQ-004 Port Op  input  2  instruction op field: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Port Funct  input  6  instruction funct field; Funct[5] = immediate (I), Funct[0] = load (L).
REQ-006 Port IRWrite  output  1  instruction register load enable.
REQ-007 Port AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-008 Port ALUSrcA  output  1  ALU A select: 0 = register, 1 = PC.
REQ-009 Port ALUSrcB  output  2  ALU B select: 00 register, 01 extended immediate, 10 constant 4.
REQ-010 Port ResultSrc  output  2  result select: 00 ALUOut, 01 read data, 10 ALU result.
REQ-011 Port NextPC  output  1  PC write for sequential fetch.
REQ-012 Port RegW  output  1  unconditioned register write; feeds condlogic.
REQ-013 Port MemW  output  1  unconditioned memory write; feeds condlogic.
REQ-014 Port Branch  output  1  unconditioned branch; feeds condlogic PCS path.
REQ-015 Port ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add.
REQ-016 Port InstrDone  output  1  high in the final cycle of each instruction.
REQ-017 Port State  output  4  current state encoding, debug and bench observation.

Function
REQ-018 The state set SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
REQ-019 The state register SHALL update on rising clk; all outputs SHALL be combinational (Moore) decodes of the current state only.
REQ-020 Transitions SHALL be: FETCH->DECODE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN->FETCH.
REQ-021 DECODE SHALL go to MEMADR if Op=01, EXECUTER if Op=00 and Funct[5]=0, EXECUTEI if Op=00 and Funct[5]=1, BRANCH if Op=10, UNKNOWN if Op=11.
REQ-022 MEMADR SHALL go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-023 Encodings 11-15 SHALL go to FETCH on the next edge, with all outputs 0.
REQ-024 FETCH outputs SHALL be: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
REQ-025 DECODE outputs SHALL be: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
REQ-026 MEMADR outputs SHALL be: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
REQ-027 MEMREAD outputs SHALL be: AdrSrc=1, ResultSrc=00.
REQ-028 MEMWB outputs SHALL be: ResultSrc=01, RegW=1.
REQ-029 MEMWRITE outputs SHALL be: AdrSrc=1, ResultSrc=00, MemW=1.
REQ-030 EXECUTER outputs SHALL be: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
REQ-031 EXECUTEI outputs SHALL be: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
REQ-032 ALUWB outputs SHALL be: ResultSrc=00, RegW=1.
REQ-033 BRANCH outputs SHALL be: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
REQ-034 Any output not listed for a state SHALL be 0; UNKNOWN SHALL drive all outputs 0 except InstrDone.
REQ-035 InstrDone SHALL be 1 in MEMWB, MEMWRITE, ALUWB, BRANCH and UNKNOWN, and 0 otherwise.
REQ-036 Latency SHALL be: load 5 cycles; store 4; data-processing 4; branch 3; undefined 3.
REQ-037 Op and Funct SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-038 rst=0 SHALL force State=FETCH immediately, without waiting for clk, including mid-instruction; an in-flight RegW or MemW SHALL drop to 0 the same instant.
REQ-039 While rst=0, outputs SHALL equal the FETCH decode; the first edge after rst rises SHALL move the state to DECODE.

Structure
REQ-040 The state enum, its 4-bit encodings and the ALUSrcB/ResultSrc select constants SHALL live in a shared package, arm_ctrl_pkg.
REQ-041 No sub-module is required; next-state logic and output decode SHALL be separate always_comb blocks in main_fsm.

Verification
REQ-042 Reset, then Op=00, Funct=000000 -> states FETCH, DECODE, EXECUTER, ALUWB; RegW=1 only in ALUWB; InstrDone pulses at cycle 4.
REQ-043 Op=01, Funct[0]=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegW=1 in MEMWB.
REQ-044 Op=01, Funct[0]=0 -> MEMWRITE in the 4th cycle with MemW=1, AdrSrc=1; next state FETCH.
REQ-045 Op=10 -> BRANCH in the 3rd cycle with Branch=1, ALUSrcB=01; Op=11 -> UNKNOWN with all controls 0, then FETCH.
REQ-046 Assert rst=0 asynchronously mid-MEMWRITE -> MemW falls to 0 before the next clk edge; State=0.
REQ-047 Op=00, Funct[5]=1 with Op toggled during EXECUTEI -> path unchanged (EXECUTEI, ALUWB, FETCH); ALUSrcB=01, ALUOp=1.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control path.
// Holds the main FSM state enum with its fixed 4-bit encodings, the
// instruction op-field codes, and the ALUSrcB / ResultSrc select constants
// used by the datapath muxes.
package arm_ctrl_pkg;

   // Main controller states; the encodings are visible on the State port.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_e;

   // Instruction op field.
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   // ALU B operand select.
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select.
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage : arm_ctrl_pkg

// File: rtl/main_fsm.sv
// Main control FSM of a multicycle ARM processor.
// Sequences every instruction through FETCH and DECODE, then through the
// memory, data-processing, branch or undefined path. All control outputs are
// Moore decodes of the current state, so an asynchronous reset removes any
// in-flight write enable immediately.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   Op         instruction op field (00 DP, 01 memory, 10 branch, 11 undef)
//   Funct      instruction funct field; [5] = immediate, [0] = load
//   IRWrite    instruction register load enable
//   AdrSrc     memory address select (0 PC, 1 ALU result)
//   ALUSrcA    ALU A select (0 register, 1 PC)
//   ALUSrcB    ALU B select (00 reg, 01 imm, 10 constant 4)
//   ResultSrc  result select (00 ALUOut, 01 read data, 10 ALU result)
//   NextPC     PC write for sequential fetch
//   RegW       unconditioned register write
//   MemW       unconditioned memory write
//   Branch     unconditioned branch
//   ALUOp      1 = ALU decoder uses Funct, 0 = add
//   InstrDone  high in the last cycle of each instruction
//   State      current state encoding
module main_fsm
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       InstrDone,
   output logic [3:0] State
);

   state_e state_q;
   state_e state_d;

   // Only the immediate and load bits steer the sequence; the rest of the
   // funct field belongs to the ALU decoder.
   logic unused_funct;
   assign unused_funct = ^Funct[4:1];

   // State register with asynchronous active-low reset to FETCH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; Op/Funct are looked at only in DECODE and MEMADR.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               OP_UND:  state_d = S_UNKNOWN;
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         // MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN and the unused
         // encodings 11-15 all return to FETCH.
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore output decode; everything defaults to 0, which is also what the
   // unused encodings 11-15 produce.
   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      InstrDone = 1'b0;
      case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            NextPC    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
         end
         S_MEMADR: begin
            ALUSrcB   = SRCB_IMM;
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_RDATA;
            RegW      = 1'b1;
            InstrDone = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemW      = 1'b1;
            InstrDone = 1'b1;
         end
         S_EXECUTER: begin
            ALUOp     = 1'b1;
         end
         S_EXECUTEI: begin
            ALUSrcB   = SRCB_IMM;
            ALUOp     = 1'b1;
         end
         S_ALUWB: begin
            RegW      = 1'b1;
            InstrDone = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALU;
            Branch    = 1'b1;
            InstrDone = 1'b1;
         end
         S_UNKNOWN: begin
            InstrDone = 1'b1;
         end
         default: begin
            IRWrite   = 1'b0;
         end
      endcase
   end

   assign State = state_q;

endmodule : main_fsm

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instruction scenarios with
// literal expectations, followed by randomized Op/Funct streams and random
// asynchronous resets, all checked every cycle against an instruction-path
// model.
module tb_main_fsm;

   logic       clk;
   logic       rst;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, InstrDone;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] State;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Model: current expected state plus the remaining states of the
   // instruction in flight.
   int exp_state = 0;
   int path[$];
   // Expected control word per state:
   // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB[1:0],ResultSrc[1:0],NextPC,RegW,MemW,Branch,ALUOp,InstrDone}
   logic [13:0] exp_tab [0:10];

   main_fsm dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .Branch(Branch), .ALUOp(ALUOp), .InstrDone(InstrDone), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] dut_word();
      return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
              RegW, MemW, Branch, ALUOp, InstrDone};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the instruction-level model by one clock edge.
   task automatic model_step();
      if (!rst) begin
         exp_state = 0;
         path.delete();
      end else begin
         if (exp_state == 1) begin
            case (Op)
               2'd0: begin path.push_back(Funct[5] ? 7 : 6); path.push_back(8); end
               2'd1: path.push_back(2);
               2'd2: path.push_back(9);
               default: path.push_back(10);
            endcase
         end else if (exp_state == 2) begin
            if (Funct[0]) begin path.push_back(3); path.push_back(4); end
            else path.push_back(5);
         end
         if (path.size() > 0) exp_state = path.pop_front();
         else if (exp_state == 0) exp_state = 1;
         else exp_state = 0;
      end
   endtask

   // One clock: model follows the edge; control returns at negedge+1.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   // Compare process: DUT state and controls against the model each cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            tests++;
            if (State !== exp_state[3:0] || dut_word() !== exp_tab[exp_state]) begin
               fails++;
               $display("FAIL cycle_cmp: got state %0d ctrl %b expected state %0d ctrl %b at %0t",
                        State, dut_word(), exp_state, exp_tab[exp_state], $time);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_tab[0]  = 14'b1_0_1_10_10_1_0_0_0_0_0;
      exp_tab[1]  = 14'b0_0_1_10_10_0_0_0_0_0_0;
      exp_tab[2]  = 14'b0_0_0_01_00_0_0_0_0_0_0;
      exp_tab[3]  = 14'b0_1_0_00_00_0_0_0_0_0_0;
      exp_tab[4]  = 14'b0_0_0_00_01_0_1_0_0_0_1;
      exp_tab[5]  = 14'b0_1_0_00_00_0_0_1_0_0_1;
      exp_tab[6]  = 14'b0_0_0_00_00_0_0_0_0_1_0;
      exp_tab[7]  = 14'b0_0_0_01_00_0_0_0_0_1_0;
      exp_tab[8]  = 14'b0_0_0_00_00_0_1_0_0_0_1;
      exp_tab[9]  = 14'b0_0_0_01_10_0_0_0_1_0_1;
      exp_tab[10] = 14'b0_0_0_00_00_0_0_0_0_0_1;

      rst = 1'b0; Op = 2'b00; Funct = 6'b000000;
      #1;
      chk_en = 1'b1;
      @(negedge clk); #1;
      cyc();
      // Held in reset: FETCH decode, edges ignored.
      chk("reset_state", State, 0);
      chk("reset_irwrite", IRWrite, 1);
      chk("reset_alusrcb", ALUSrcB, 2);
      rst = 1'b1;

      // Data-processing register: FETCH, DECODE, EXECUTER, ALUWB.
      cyc(); chk("dp_decode", State, 1);
      chk("dp_decode_regw", RegW, 0);
      cyc(); chk("dp_executer", State, 6);
      chk("dp_executer_aluop", ALUOp, 1);
      chk("dp_executer_regw", RegW, 0);
      cyc(); chk("dp_aluwb", State, 8);
      chk("dp_aluwb_regw", RegW, 1);
      chk("dp_aluwb_done", InstrDone, 1);
      cyc(); chk("dp_back_fetch", State, 0);

      // Load: 5 cycles.
      Op = 2'b01; Funct = 6'b000001;
      cyc(); chk("ld_decode", State, 1);
      cyc(); chk("ld_memadr", State, 2);
      cyc(); chk("ld_memread", State, 3);
      chk("ld_memread_adrsrc", AdrSrc, 1);
      cyc(); chk("ld_memwb", State, 4);
      chk("ld_memwb_result", ResultSrc, 1);
      chk("ld_memwb_regw", RegW, 1);
      cyc(); chk("ld_back_fetch", State, 0);

      // Store, then async reset in the middle of MEMWRITE.
      Op = 2'b01; Funct = 6'b000000;
      cyc(); cyc();
      chk("st_memadr", State, 2);
      cyc(); chk("st_memwrite", State, 5);
      chk("st_memw", MemW, 1);
      chk("st_adrsrc", AdrSrc, 1);
      #2;
      rst = 1'b0; exp_state = 0; path.delete();
      #1;
      chk("async_memw_drop", MemW, 0);
      chk("async_state", State, 0);
      cyc();
      rst = 1'b1;

      // Branch: 3 cycles.
      Op = 2'b10; Funct = 6'b000000;
      cyc(); cyc(); chk("br_branch", State, 9);
      chk("br_branch_sig", Branch, 1);
      chk("br_alusrcb", ALUSrcB, 1);
      cyc(); chk("br_back_fetch", State, 0);

      // Undefined: 3 cycles, all controls 0 except InstrDone.
      Op = 2'b11;
      cyc(); cyc(); chk("und_state", State, 10);
      chk("und_ctrl", dut_word(), 1);
      cyc(); chk("und_back_fetch", State, 0);

      // Immediate DP with Op disturbed during EXECUTEI.
      Op = 2'b00; Funct = 6'b100000;
      cyc(); cyc(); chk("dpi_executei", State, 7);
      chk("dpi_alusrcb", ALUSrcB, 1);
      chk("dpi_aluop", ALUOp, 1);
      Op = 2'b10; Funct = 6'b011111;
      cyc(); chk("dpi_aluwb", State, 8);
      cyc(); chk("dpi_back_fetch", State, 0);

      // Randomized stream with occasional asynchronous resets.
      for (int i = 0; i < 800; i++) begin
         Op    = 2'($urandom_range(0, 3));
         Funct = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 39) == 0) begin
            #($urandom_range(1, 2));
            rst = 1'b0; exp_state = 0; path.delete();
            #1;
            chk("rnd_async_state", State, 0);
            chk("rnd_async_writes", {RegW, MemW}, 0);
            cyc();
            rst = 1'b1;
         end else begin
            cyc();
         end
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_main_fsm
